// File: rtl/ir_tx_sequencer_pkg.sv
// Shared encodings, state type and phase-shape helpers for the IR transmit sequencer.
// The helpers give each phase's carrier level and whether it uses the long length.
package ir_tx_pkg;

    localparam logic [1:0] IR_MODE_BIPHASE = 2'd0;
    localparam logic [1:0] IR_MODE_PDIST   = 2'd1;
    localparam logic [1:0] IR_MODE_PLEN    = 2'd2;
    localparam logic [1:0] IR_MODE_ILLEGAL = 2'd3;

    localparam int unsigned IR_N_SHORT_DEF = 32;
    localparam int unsigned IR_N_LONG_DEF  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH1  = 2'd1,
        PH2  = 2'd2,
        GAP  = 2'd3
    } ir_state_e;

    function automatic logic ph1_level(input logic [1:0] mode, input logic b);
        return (mode == IR_MODE_BIPHASE) ? ~b : 1'b1;
    endfunction

    function automatic logic ph2_level(input logic [1:0] mode, input logic b);
        return (mode == IR_MODE_BIPHASE) ? b : 1'b0;
    endfunction

    function automatic logic ph1_long(input logic [1:0] mode, input logic b);
        return (mode == IR_MODE_PLEN) && b;
    endfunction

    function automatic logic ph2_long(input logic [1:0] mode, input logic b);
        return (mode == IR_MODE_PDIST) && b;
    endfunction

endpackage

// File: rtl/ir_tx_sequencer_if.sv
// Frame request channel: valid/ready handshake plus the request fields.
interface ir_tx_sequencer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic [1:0]        i_req_mode;
    logic [DATA_W-1:0] i_req_data;
    logic [5:0]        i_req_bits;
    logic [CNT_W-1:0]  i_gap_ticks;

    modport master (
        output i_req_valid,
        output i_req_mode,
        output i_req_data,
        output i_req_bits,
        output i_gap_ticks,
        input  o_req_ready
    );

    modport slave (
        input  i_req_valid,
        input  i_req_mode,
        input  i_req_data,
        input  i_req_bits,
        input  i_gap_ticks,
        output o_req_ready
    );
endinterface

// File: rtl/ir_tx_sequencer_phase_timer.sv
// Carrier-tick counter shared by the bit phases and the inter-frame gap.
// o_term fires on the tick that completes len ticks; the count then restarts at zero.
module ir_phase_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tick,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_len,
    output logic             o_term
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_term;

    assign w_term = i_tick && (r_cnt == (i_len - CNT_W'(1)));
    assign o_term = w_term;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear || w_term) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ir_tx_sequencer.sv
// Frame-level IR transmit controller: serialises a latched payload LSB-first as
// bi-phase, pulse-distance or pulse-length phases timed in carrier ticks, then a gap.
module ir_tx_sequencer
    import ir_tx_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned N_SHORT = IR_N_SHORT_DEF,
    parameter int unsigned N_LONG  = IR_N_LONG_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_carrier,
    input  logic             i_carrier_tick,
    ir_tx_sequencer_if.slave req_if,
    input  logic             i_abort,
    output logic             o_ir_mark,
    output logic             o_ir_dout,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam logic [CNT_W-1:0] LEN_SHORT = CNT_W'(N_SHORT);
    localparam logic [CNT_W-1:0] LEN_LONG  = CNT_W'(N_LONG);
    localparam logic [5:0]       MAX_BITS  = 6'(DATA_W);

    ir_state_e         r_state;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_data;
    logic [5:0]        r_bits;
    logic [CNT_W-1:0]  r_gap;
    logic              r_mark;
    logic              r_done;
    logic              r_err;

    ir_state_e         w_state_nxt;
    logic [1:0]        w_mode_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic [5:0]        w_bits_nxt;
    logic [CNT_W-1:0]  w_gap_nxt;
    logic              w_mark_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;

    logic              w_accept;
    logic [5:0]        w_bits_clamped;
    logic [CNT_W-1:0]  w_len;
    logic              w_term;
    logic              w_clear;

    assign w_accept       = req_if.i_req_valid && (r_state == IDLE);
    assign w_bits_clamped = (req_if.i_req_bits > MAX_BITS) ? MAX_BITS : req_if.i_req_bits;
    assign w_clear        = (r_state == IDLE);

    ir_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_tick  (i_carrier_tick),
        .i_clear (w_clear),
        .i_len   (w_len),
        .o_term  (w_term)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_mode  <= '0;
            r_data  <= '0;
            r_bits  <= '0;
            r_gap   <= '0;
            r_mark  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_data  <= w_data_nxt;
            r_bits  <= w_bits_nxt;
            r_gap   <= w_gap_nxt;
            r_mark  <= w_mark_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_data_nxt  = r_data;
        w_bits_nxt  = r_bits;
        w_gap_nxt   = r_gap;
        w_mark_nxt  = r_mark;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_len       = LEN_SHORT;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_mode_nxt = req_if.i_req_mode;
                    w_data_nxt = req_if.i_req_data;
                    w_bits_nxt = w_bits_clamped;
                    w_gap_nxt  = req_if.i_gap_ticks;
                    w_mark_nxt = 1'b0;
                    if (req_if.i_req_mode == IR_MODE_ILLEGAL) begin
                        w_done_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end else if (w_bits_clamped != '0) begin
                        w_state_nxt = PH1;
                        w_mark_nxt  = ph1_level(req_if.i_req_mode, req_if.i_req_data[0]);
                    end else if (req_if.i_gap_ticks != '0) begin
                        w_state_nxt = GAP;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            PH1: begin
                w_len = ph1_long(r_mode, r_data[0]) ? LEN_LONG : LEN_SHORT;
                if (w_term) begin
                    w_state_nxt = PH2;
                    w_mark_nxt  = ph2_level(r_mode, r_data[0]);
                end
            end
            PH2: begin
                w_len = ph2_long(r_mode, r_data[0]) ? LEN_LONG : LEN_SHORT;
                if (w_term) begin
                    if (r_bits > 6'd1) begin
                        // Next bit's PH1 level comes from r_data[1], before the shift lands.
                        w_data_nxt  = r_data >> 1;
                        w_bits_nxt  = r_bits - 6'd1;
                        w_state_nxt = PH1;
                        w_mark_nxt  = ph1_level(r_mode, r_data[1]);
                    end else if (r_gap != '0) begin
                        w_state_nxt = GAP;
                        w_mark_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_mark_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            GAP: begin
                w_len = r_gap;
                if (w_term) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_mark_nxt  = 1'b0;
            end
        endcase

        // Abort overrides everything, including a coincident terminal tick.
        if ((r_state != IDLE) && i_abort) begin
            w_state_nxt = IDLE;
            w_mark_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
        end
    end

    assign req_if.o_req_ready = (r_state == IDLE);
    assign o_ir_mark          = r_mark;
    assign o_ir_dout          = r_mark & i_carrier;
    assign o_busy             = (r_state != IDLE);
    assign o_done             = r_done;
    assign o_err              = r_err;

endmodule

// File: tb/tb_ir_tx_sequencer.sv
// Self-checking bench: a segment-list model of each frame predicts every output per cycle.
`timescale 1ns/1ps
module tb_ir_tx_sequencer;
    import ir_tx_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int NS = 32;
    localparam int NL = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic carrier = 1'b0;
    logic tick = 1'b0;
    logic abort = 1'b0;
    logic mark, dout, busy, done, err;

    ir_tx_sequencer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) req_if ();

    ir_tx_sequencer #(
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W),
        .N_SHORT (NS),
        .N_LONG  (NL)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_carrier      (carrier),
        .i_carrier_tick (tick),
        .req_if         (req_if.slave),
        .i_abort        (abort),
        .o_ir_mark      (mark),
        .o_ir_dout      (dout),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Carrier and tick stimulus: tick every 4 clocks, or random density later on.
    int tick_mode = 0;
    initial begin
        int cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (tick_mode == 0) tick = ((cyc % 4) == 0);
            else                tick = ($urandom_range(1, 0) == 1);
            carrier = ($urandom_range(1, 0) == 1);
        end
    end

    // Behavioural model: a frame is a list of (level, length-in-ticks) segments.
    int   seg_lvl[$];
    int   seg_len[$];
    int   seg_cnt = 0;
    logic m_mark = 1'b0;
    logic m_done = 1'b0;
    logic m_err  = 1'b0;

    function automatic void build(input logic [1:0] md, input logic [31:0] d, input int bits, input int gap);
        int nb;
        nb = (bits > 32) ? 32 : bits;
        seg_lvl.delete();
        seg_len.delete();
        if (md == 2'd3) return;
        for (int i = 0; i < nb; i++) begin
            int b;
            b = d[i];
            case (md)
                2'd0: begin
                    seg_lvl.push_back(1 - b); seg_len.push_back(NS);
                    seg_lvl.push_back(b);     seg_len.push_back(NS);
                end
                2'd1: begin
                    seg_lvl.push_back(1); seg_len.push_back(NS);
                    seg_lvl.push_back(0); seg_len.push_back(b ? NL : NS);
                end
                default: begin
                    seg_lvl.push_back(1); seg_len.push_back(b ? NL : NS);
                    seg_lvl.push_back(0); seg_len.push_back(NS);
                end
            endcase
        end
        if (gap > 0) begin
            seg_lvl.push_back(0);
            seg_len.push_back(gap);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                seg_lvl.delete();
                seg_len.delete();
                seg_cnt = 0;
                m_mark = 1'b0;
                m_done = 1'b0;
                m_err  = 1'b0;
            end else begin
                m_done = 1'b0;
                m_err  = 1'b0;
                if (seg_len.size() != 0) begin
                    if (abort) begin
                        seg_lvl.delete();
                        seg_len.delete();
                        seg_cnt = 0;
                        m_done = 1'b1;
                        m_err  = 1'b1;
                    end else if (tick) begin
                        seg_cnt++;
                        if (seg_cnt == seg_len[0]) begin
                            void'(seg_lvl.pop_front());
                            void'(seg_len.pop_front());
                            seg_cnt = 0;
                            if (seg_len.size() == 0) m_done = 1'b1;
                        end
                    end
                end else if (req_if.i_req_valid) begin
                    build(req_if.i_req_mode, req_if.i_req_data, int'(req_if.i_req_bits), int'(req_if.i_gap_ticks));
                    seg_cnt = 0;
                    if (req_if.i_req_mode == 2'd3) begin
                        m_done = 1'b1;
                        m_err  = 1'b1;
                    end else if (seg_len.size() == 0) begin
                        m_done = 1'b1;
                    end
                end
                m_mark = (seg_lvl.size() != 0) ? (seg_lvl[0] != 0) : 1'b0;
            end
        end
    end

    // Per-cycle compare plus per-frame statistics (reset after the accepting cycle).
    int mark_ticks = 0, busy_ticks = 0, done_cnt = 0, err_cnt = 0, first_mark = -1, rdy_busy = 0;
    initial begin
        forever begin
            logic m_busy;
            @(negedge clk);
            m_busy = (seg_len.size() != 0);
            chk("mark", mark, m_mark);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("dout", dout, m_mark & carrier);
            if (!rst) chk("ready", req_if.o_req_ready, !m_busy);
            if (mark && first_mark < 0) first_mark = busy_ticks;
            if (mark && tick) mark_ticks++;
            if (busy && tick) busy_ticks++;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (busy && req_if.o_req_ready) rdy_busy++;
            if (!rst && !m_busy && req_if.i_req_valid) begin
                mark_ticks = 0; busy_ticks = 0; done_cnt = 0;
                err_cnt = 0; first_mark = -1; rdy_busy = 0;
            end
        end
    end

    task automatic send(input logic [1:0] md, input logic [31:0] d, input int bits, input int gap);
        int n = 0;
        req_if.i_req_valid = 1'b1;
        req_if.i_req_mode  = md;
        req_if.i_req_data  = d;
        req_if.i_req_bits  = 6'(bits);
        req_if.i_gap_ticks = CNT_W'(gap);
        @(negedge clk);
        while (!req_if.o_req_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", (n < 5000), 1'b1);
        @(posedge clk);
        #1;
        req_if.i_req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while ((busy || seg_len.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", (n < budget), 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n;
        req_if.i_req_valid = 1'b0;
        req_if.i_req_mode  = '0;
        req_if.i_req_data  = '0;
        req_if.i_req_bits  = '0;
        req_if.i_gap_ticks = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mark", mark, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_if.o_req_ready, 1'b1);
        @(posedge clk); #1;

        // Bi-phase 0b101: space/mark, mark/space, space/mark.
        send(2'd0, 32'h5, 3, 0);
        wait_idle(3000);
        chk("t1_mark_ticks", mark_ticks, 96);
        chk("t1_frame_ticks", busy_ticks, 192);
        chk("t1_first_mark", first_mark, 32);
        chk("t1_done", done_cnt, 1);
        chk("t1_err", err_cnt, 0);

        // Pulse-distance 0b10 with gap 10.
        send(2'd1, 32'h2, 2, 10);
        wait_idle(3000);
        chk("t2_mark_ticks", mark_ticks, 64);
        chk("t2_frame_ticks", busy_ticks, 170);
        chk("t2_first_mark", first_mark, 0);
        chk("t2_ready_busy", rdy_busy, 0);
        chk("t2_done", done_cnt, 1);

        // Pulse-length 0b01.
        send(2'd2, 32'h1, 2, 0);
        wait_idle(3000);
        chk("t3_mark_ticks", mark_ticks, 96);
        chk("t3_frame_ticks", busy_ticks, 160);
        chk("t3_first_mark", first_mark, 0);
        chk("t3_err", err_cnt, 0);

        // Illegal mode.
        send(2'd3, 32'hFF, 5, 7);
        @(negedge clk);
        chk("t4_done", done, 1'b1);
        chk("t4_err", err, 1'b1);
        chk("t4_mark", mark, 1'b0);
        chk("t4_busy", busy, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_ready", req_if.o_req_ready, 1'b1);
        chk("t4_done_clear", done, 1'b0);
        @(posedge clk); #1;

        // Abort a 14-bit bi-phase frame, then re-request at once.
        send(2'd0, $urandom, 14, 5);
        n = 0;
        while (busy_ticks < 40 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_tick40", (n < 2000), 1'b1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        req_if.i_req_valid = 1'b1;
        req_if.i_req_mode  = 2'd1;
        req_if.i_req_data  = 32'h3;
        req_if.i_req_bits  = 6'd2;
        req_if.i_gap_ticks = '0;
        @(negedge clk);
        chk("t5_abort_done", done, 1'b1);
        chk("t5_abort_err", err, 1'b1);
        chk("t5_abort_mark", mark, 1'b0);
        chk("t5_abort_ready", req_if.o_req_ready, 1'b1);
        @(posedge clk); #1 req_if.i_req_valid = 1'b0;
        @(negedge clk);
        chk("t5_reaccept_busy", busy, 1'b1);
        wait_idle(3000);
        chk("t5_mark_ticks", mark_ticks, 64);
        chk("t5_frame_ticks", busy_ticks, 192);
        chk("t5_done", done_cnt, 1);
        chk("t5_err", err_cnt, 0);

        // Async reset mid-mark, then an empty request.
        send(2'd0, 32'h0, 4, 0);
        n = 0;
        while (mark_ticks < 10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reach_mark", (n < 2000), 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("t6_rst_mark", mark, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_dout", dout, 1'b0);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        send(2'd0, 32'hFFFF_FFFF, 0, 0);
        @(negedge clk);
        chk("t6_empty_done", done, 1'b1);
        chk("t6_empty_err", err, 1'b0);
        chk("t6_empty_mark", mark, 1'b0);
        chk("t6_empty_busy", busy, 1'b0);
        @(posedge clk); #1;

        // Randomized frames, aborts and hold-off attempts.
        tick_mode = 1;
        for (int it = 0; it < 24; it++) begin
            logic [1:0] md;
            int bits, gap, act;
            md   = ($urandom_range(9, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
            bits = $urandom_range(8, 0);
            gap  = $urandom_range(12, 0);
            act  = $urandom_range(3, 0);
            if (it == 0) begin
                md = 2'd0; bits = 40; gap = 0; act = 3;
            end
            send(md, $urandom, bits, gap);
            if (act == 0) begin
                n = $urandom_range(200, 1);
                repeat (n) @(negedge clk);
                @(posedge clk); #1 abort = 1'b1;
                @(posedge clk); #1 abort = 1'b0;
            end else if (act == 1) begin
                req_if.i_req_valid = 1'b1;
                req_if.i_req_mode  = 2'($urandom_range(3, 0));
                req_if.i_req_data  = $urandom;
                req_if.i_req_bits  = 6'($urandom_range(4, 0));
                req_if.i_gap_ticks = CNT_W'($urandom_range(5, 0));
                repeat (5) @(posedge clk);
                #1 req_if.i_req_valid = 1'b0;
            end
            wait_idle(20000);
            if (it == 0) begin
                chk("clamp_frame_ticks", busy_ticks, 2048);
                chk("clamp_mark_ticks", mark_ticks, 1024);
            end
        end

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ir_tx_sequencer.md
Name: ir_tx_sequencer

Overview:
Frame-level controller for the IR transmit path. It accepts one frame request at a time and serialises the payload LSB-first in bi-phase, pulse-distance or pulse-length coding. Each bit phase is timed in carrier periods, and the block gates the carrier into the IR output. After the frame it enforces an inter-frame gap. It sits between the register/command interface and the carrier divider/IR pad.

Parameters:
DATA_W, 32, maximum payload bits per frame
CNT_W, 16, width of the phase and gap counters (carrier periods)
N_SHORT, 32, short phase length in carrier periods
N_LONG, 64, long phase length in carrier periods

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-high
i_carrier  in  1  raw carrier waveform from the carrier divider
i_carrier_tick  in  1  one-cycle pulse, once per carrier period
i_req_valid  in  1  frame request valid
o_req_ready  out  1  block idle and able to accept
i_req_mode  in  2  0 = bi-phase, 1 = pulse-distance, 2 = pulse-length, 3 = illegal
i_req_data  in  DATA_W  payload, LSB sent first
i_req_bits  in  6  bit count, 0..32
i_gap_ticks  in  CNT_W  inter-frame gap in carrier periods
i_abort  in  1  synchronous abort of the current frame
o_ir_mark  out  1  1 = carrier-on phase
o_ir_dout  out  1  o_ir_mark AND i_carrier (combinational)
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse at frame end
o_err  out  1  one-cycle pulse, coincident with o_done, on illegal mode or abort

Behaviour:
- Reset (async, active-high): state = IDLE; all counters 0; o_ir_mark = 0, o_busy = 0, o_done = 0, o_err = 0; o_req_ready = 1 after reset deasserts. Reset mid-frame kills the output immediately.
- Accept occurs when i_req_valid & o_req_ready. o_req_ready = (state == IDLE). On accept, mode, data, bits and gap are latched. bits > 32 is clamped to 32.
- States:
  - IDLE: wait for accept.
  - PH1: first half of the bit.
  - PH2: second half of the bit.
  - GAP: inter-frame gap.
- Phase contents per bit b:
  - bi-phase: b = 1 gives PH1 space N_SHORT, PH2 mark N_SHORT. b = 0 gives PH1 mark N_SHORT, PH2 space N_SHORT.
  - pulse-distance: PH1 mark N_SHORT. PH2 space N_SHORT if b = 0, N_LONG if b = 1.
  - pulse-length: PH1 mark N_SHORT if b = 0, N_LONG if b = 1. PH2 space N_SHORT.
- Timing:
  - o_ir_mark is registered. It takes the PH1 level in the cycle after accept.
  - The phase counter increments on i_carrier_tick. On the tick where cnt == len-1, cnt clears and the next phase's level is registered in the following cycle.
  - Each phase therefore lasts exactly len ticks.
- Sequence:
  - After PH2 of a non-last bit: shift data right, decrement the bit count, go to PH1.
  - After PH2 of the last bit: go to GAP with o_ir_mark = 0.
  - GAP lasts gap ticks, then IDLE with an o_done pulse.
  - If gap == 0, go straight from the last PH2 to IDLE and pulse o_done.
- Request edge cases:
  - bits == 0 with a legal mode: no phases. Go to GAP (or IDLE if gap == 0), then o_done.
  - mode == 3: accepted. Next cycle o_done = 1 and o_err = 1, state stays IDLE, no output.
- i_abort: in any non-IDLE state, the next cycle gives o_ir_mark = 0, state IDLE, o_done = 1, o_err = 1. The gap is skipped. i_abort is ignored in IDLE.
- Simultaneous abort and terminal tick: abort wins.
- A request presented during busy is held off by ready = 0. No queueing.
- The counter never wraps, because the terminal compare always precedes overflow. The N_LONG-1 value must fit in CNT_W.

Decomposition:
- Package ir_tx_pkg holds:
  - mode encodings IR_MODE_BIPHASE = 2'd0, IR_MODE_PDIST = 2'd1, IR_MODE_PLEN = 2'd2
  - state enum {IDLE, PH1, PH2, GAP}
  - default N_SHORT and N_LONG constants
- One sub-module, ir_phase_timer: a tick counter with load-length and clear inputs and a terminal flag (cnt == len-1 & tick). It is instantiated once and shared by the phase and gap timing.

Test Plan:
All scenarios use i_carrier_tick every 4 clocks.
1. Bi-phase, data 0x5, bits 3, gap 0 -> marks at ticks [32,64), [64,96), [160,192). Total mark 96 ticks, frame 192 ticks, then one o_done pulse with o_err = 0.
2. Pulse-distance, data 0b10, bits 2, gap 10 -> mark 32 / space 32 / mark 32 / space 64 / gap 10. o_done occurs 170 ticks after the first mark, and ready is low throughout.
3. Pulse-length, data 0b01, bits 2 -> mark 64 / space 32 / mark 32 / space 32. Check o_ir_dout equals i_carrier only during marks.
4. Mode 3 request -> o_done = o_err = 1 one cycle after accept, o_ir_mark stays 0, and ready returns 1 the next cycle.
5. i_abort at tick 40 of a 14-bit bi-phase frame -> o_ir_mark = 0 next cycle, o_done = o_err = 1, and a new request is accepted immediately.
6. i_rst asserted mid-mark -> o_ir_mark, o_busy and o_ir_dout are 0 in the same cycle (async). A bits = 0, gap = 0 request after release gives o_done one cycle after accept, with no mark.
